// File: rtl/au_inc_seq_pkg.sv
// Shared definitions for the sequential arith-unit blocks: FSM state
// encodings and the slice-index width helper.
package au_inc_seq_pkg;

  localparam logic [1:0] AU_ST_IDLE = 2'd0;
  localparam logic [1:0] AU_ST_RUN  = 2'd1;
  localparam logic [1:0] AU_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = AU_ST_IDLE,
    ST_RUN  = AU_ST_RUN,
    ST_DONE = AU_ST_DONE
  } au_state_t;

  // A one-slice operand still gets a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/au_inc_seq_inc.sv
// AU_inc: combinational +1 of a WIDTH-bit operand. ARCH picks how the
// prefix-AND carry chain is built (0 ripple, 1 Kogge-Stone, 2 flat per bit).
module AU_inc #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_z
);

  // w_gen[i] is the carry "generate" into bit i: constant 1 at bit 0.
  logic [WIDTH-1:0] w_gen;
  logic [WIDTH-1:0] w_carry;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_gen
      if (gi == 0) begin : g_lsb
        assign w_gen[gi] = 1'b1;
      end else begin : g_up
        assign w_gen[gi] = i_a[gi-1];
      end
    end

    if (ARCH == 1) begin : g_ks
      always_comb begin
        logic [WIDTH-1:0] v_lvl;
        logic [WIDTH-1:0] v_nxt;
        v_lvl = w_gen;
        v_nxt = w_gen;
        for (int l = 0; (1 << l) < WIDTH; l++) begin
          v_nxt = v_lvl;
          for (int i = (1 << l); i < WIDTH; i++) begin
            v_nxt[i] = v_lvl[i] & v_lvl[i-(1<<l)];
          end
          v_lvl = v_nxt;
        end
        w_carry = v_lvl;
      end
    end else if (ARCH == 2) begin : g_flat
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign w_carry[gi] = &w_gen[gi:0];
      end
    end else begin : g_ripple
      always_comb begin
        logic v_c;
        v_c     = 1'b1;
        w_carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
          v_c        = v_c & w_gen[i];
          w_carry[i] = v_c;
        end
      end
    end
  endgenerate

  assign o_z = i_a ^ w_carry;

endmodule

// File: rtl/au_inc_seq.sv
// Multi-cycle wide incrementer: one shared AU_inc slice walks the operand
// LSB-first and stops at the first slice that does not overflow.
module au_inc_seq
  import au_inc_seq_pkg::*;
#(
  parameter int SLICE  = 8,
  parameter int NSLICE = 4,
  parameter int ARCH   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [SLICE*NSLICE-1:0] a,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [SLICE*NSLICE-1:0] z,
  output logic                    cout
);

  localparam int WIDTH = SLICE * NSLICE;
  localparam int IDX_W = idx_width(NSLICE);

  au_state_t              r_state;
  au_state_t              w_state_next;
  logic [IDX_W-1:0]       r_idx;
  logic [WIDTH-1:0]       r_z;
  logic                   r_cout;

  logic [31:0]            w_base;
  logic [SLICE-1:0]       w_slice;
  logic [SLICE-1:0]       w_inc_z;
  logic                   w_all_ones;
  logic                   w_last;
  logic                   w_ready;
  logic                   w_accept;

  assign w_base     = 32'(r_idx) * 32'(SLICE);
  assign w_slice    = r_z[w_base +: SLICE];
  // Overflow is judged on the input slice, not recovered from the incrementer.
  assign w_all_ones = &w_slice;
  assign w_last     = (r_idx == IDX_W'(NSLICE - 1));
  assign w_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept   = w_ready && start;

  AU_inc #(
    .WIDTH (SLICE),
    .ARCH  (ARCH)
  ) u_inc (
    .i_a (w_slice),
    .o_z (w_inc_z)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  w_state_next = (w_all_ones && !w_last) ? ST_RUN : ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_z     <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_z    <= a;
        r_idx  <= '0;
        r_cout <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_z[w_base +: SLICE] <= w_inc_z;
        if (w_all_ones) begin
          if (w_last) r_cout <= 1'b1;
          else        r_idx  <= r_idx + 1'b1;
        end
      end
    end
  end

  assign ready = w_ready;
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign z     = r_z;
  assign cout  = r_cout;

endmodule

// File: tb/tb_au_inc_seq.sv
// Randomized check of au_inc_seq against an arithmetic reference (a+1,
// overflow, latency from the count of low all-ones slices).
module tb_au_inc_seq;

  localparam int SL = 8;
  localparam int NS = 4;
  localparam int W  = SL * NS;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         start, ready, busy, done, cout;
  logic [W-1:0] a, z;
  logic         s1_start, s1_ready, s1_busy, s1_done, s1_cout;
  logic [0:0]   s1_a, s1_z;
  logic         s3_start, s3_ready, s3_busy, s3_done, s3_cout;
  logic [8:0]   s3_a, s3_z;

  int n_vec = 0;
  int n_err = 0;

  au_inc_seq #(.SLICE(SL), .NSLICE(NS), .ARCH(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .ready(ready),
    .busy(busy), .done(done), .z(z), .cout(cout)
  );

  au_inc_seq #(.SLICE(1), .NSLICE(1), .ARCH(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .ready(s1_ready),
    .busy(s1_busy), .done(s1_done), .z(s1_z), .cout(s1_cout)
  );

  au_inc_seq #(.SLICE(3), .NSLICE(3), .ARCH(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(s3_start), .a(s3_a), .ready(s3_ready),
    .busy(s3_busy), .done(s3_done), .z(s3_z), .cout(s3_cout)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Latency = 1 (start cycle) + m, m = 1 + number of low all-ones slices, capped.
  function automatic int ref_lat(input logic [W-1:0] op);
    int m;
    m = 1;
    while (m < NS && ((op >> ((m - 1) * SL)) & 32'hFF) == 32'hFF) m++;
    return m + 1;
  endfunction

  // Called at a negedge with the DUT in IDLE or DONE; returns at the done cycle.
  task automatic do_op(input logic [W-1:0] op, input bit poke);
    logic [W:0] sum;
    int lat, cyc;
    sum = {1'b0, op} + 33'd1;
    lat = ref_lat(op);
    check_val("ready_at_start", 64'(ready), 64'd1);
    start = 1'b1;
    a     = op;
    @(negedge clk);
    cyc   = 1;
    start = poke;
    a     = $urandom;
    check_val("busy_run", 64'(busy), 64'd1);
    while (done !== 1'b1 && cyc < NS + 6) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    check_val("latency", 64'(cyc), 64'(lat));
    check_val("z", 64'(z), 64'(sum[W-1:0]));
    check_val("cout", 64'(cout), 64'(sum[W]));
    check_val("busy_done", 64'(busy), 64'd0);
    $display("op a=%08h poke=%0d -> z=%08h cout=%0d latency=%0d (ref z=%08h cout=%0d latency=%0d)",
             op, poke, z, cout, cyc, sum[W-1:0], sum[W], lat);
  endtask

  task automatic small_op(input int sel, input logic [8:0] op, input logic [8:0] exp_z,
                          input logic exp_c, input int exp_lat);
    int cyc;
    logic d;
    if (sel == 1) begin s1_start = 1'b1; s1_a = op[0:0]; end
    else          begin s3_start = 1'b1; s3_a = op;      end
    @(negedge clk);
    cyc = 1;
    s1_start = 1'b0;
    s3_start = 1'b0;
    while (cyc < 10) begin
      d = (sel == 1) ? s1_done : s3_done;
      if (d === 1'b1) break;
      @(negedge clk);
      cyc++;
    end
    check_val("small_latency", 64'(cyc), 64'(exp_lat));
    check_val("small_z", (sel == 1) ? 64'(s1_z) : 64'(s3_z), 64'(exp_z));
    check_val("small_cout", (sel == 1) ? 64'(s1_cout) : 64'(s3_cout), 64'(exp_c));
    $display("small%0d a=%03h -> z=%03h cout=%0d latency=%0d", sel, op,
             (sel == 1) ? 9'(s1_z) : s3_z, (sel == 1) ? s1_cout : s3_cout, cyc);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] op;
    int k;
    start = 1'b0; a = '0;
    s1_start = 1'b0; s1_a = '0;
    s3_start = 1'b0; s3_a = '0;

    // Asynchronous reset: effective before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_z", 64'(z), 64'd0);
    check_val("rst_cout", 64'(cout), 64'd0);
    check_val("rst_ready", 64'(ready), 64'd1);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'h0000_0012, 1'b0);
    check_val("upper_slices", 64'(z[31:8]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check_val("hold_z", 64'(z), 64'h13);
    check_val("idle_done", 64'(done), 64'd0);
    check_val("idle_ready", 64'(ready), 64'd1);

    do_op(32'h0000_FFFF, 1'b0);
    @(negedge clk);
    do_op(32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    do_op(32'h0000_0034, 1'b1);
    do_op(32'h0000_00FE, 1'b0);
    @(negedge clk);

    // Reset in cycle 2 of a full-carry run aborts it without a done pulse.
    start = 1'b1; a = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_z", 64'(z), 64'd0);
    check_val("abort_cout", 64'(cout), 64'd0);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_ready", 64'(ready), 64'd1);
    check_val("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("no_done_after_abort", 64'(done), 64'd0);
    end
    do_op(32'h0000_007F, 1'b0);
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, NS);
      op = $urandom;
      for (int j = 0; j < k; j++) op[j*SL +: SL] = 8'hFF;
      do_op(op, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    small_op(1, 9'h001, 9'h000, 1'b1, 2);
    small_op(1, 9'h000, 9'h001, 1'b0, 2);
    small_op(3, 9'h1FF, 9'h000, 1'b1, 4);
    small_op(3, 9'h007, 9'h008, 1'b0, 3);
    small_op(3, 9'h03F, 9'h040, 1'b0, 4);
    small_op(3, 9'h0A5, 9'h0A6, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/au_inc_seq.md
# AU_inc_seq

Multi-cycle wide incrementer that sequences one narrow `AU_inc` slice over a wide operand, least-significant slice first. It stops early as soon as a slice does not overflow. It sits beside the combinational incrementers as the area-optimised option for wide counters and address or sequence-number generators, where latency is acceptable. A start/ready/done handshake controls it.

## Interface
- `SLICE`, 8, slice width in bits (>= 1); width of the shared `AU_inc` instance
- `NSLICE`, 4, number of slices (>= 1); operand width `WIDTH = SLICE*NSLICE`
- `ARCH`, 0, prefix architecture (0 to 2), passed unchanged to `AU_inc`

- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  request to increment `a`; accepted only when `ready=1`
- `a`  in  WIDTH  operand, sampled on the accepting edge only
- `ready`  out  1  block can accept `start` (state IDLE or DONE)
- `busy`  out  1  operation in progress (state RUN)
- `done`  out  1  one-cycle pulse: `z`/`cout` hold the final result
- `z`  out  WIDTH  working/result register, `a + 1` modulo 2^WIDTH
- `cout`  out  1  overflow flag, set when `a` was all ones

## Operation
- State machine, registered: IDLE -> RUN on accepted start; RUN -> RUN while the current slice is all ones and is not the last slice; RUN -> DONE otherwise; DONE -> IDLE, or DONE -> RUN if `start=1`.
- Accepting `start` does the following:
  - `z <= a`
  - slice index `idx <= 0`
  - `cout <= 0`
- Each RUN cycle processes slice `s = z[idx*SLICE +: SLICE]`, feeding it to `AU_inc`:
  - Slice not all ones: the slice is replaced by the `AU_inc` output, and the state goes to DONE (early termination; higher slices are untouched).
  - Slice all ones: the slice is replaced by the `AU_inc` output (all zeros).
    - If `idx < NSLICE-1`: `idx <= idx+1` and the state stays in RUN.
    - If `idx == NSLICE-1`: `cout <= 1` and the state goes to DONE.
- All-ones detection is the AND-reduction of `s`, computed locally. The carry is not taken from the `AU_inc` output.
- `idx` width is `max(1, clog2(NSLICE))`. `idx` never exceeds `NSLICE-1`.
- `start` while RUN is ignored; `a` is not sampled.
- In DONE, `done=1`, `ready=1`, and `start` is accepted. Back-to-back operation is legal, and the new operand overwrites `z` at that edge.
- After DONE -> IDLE, `z` and `cout` hold their values until the next accepted start.
- `NSLICE=1`: a single RUN cycle; `cout` = AND-reduction of `a`.

## Timing
- Reset (`rst_n=0`, takes effect immediately): state IDLE, `z=0`, `cout=0`, `idx=0`, `done=0`, `busy=0`, `ready=1`.
- Reset asserted mid-RUN aborts the operation with no `done` pulse. The block is ready immediately after `rst_n` deasserts.
- Cycle counting: `start` is high in cycle 0 and sampled at its end. RUN occupies cycles 1..m, where m = 1 + number of consecutive all-ones slices from slice 0, capped at NSLICE. `done` is high in cycle m+1.
- Latency is m+1 cycles from start to done. Minimum is 2, maximum is NSLICE+1.
- During RUN, `z` holds a partially updated value and is not valid.
- `ready`, `busy`, and `done` are decoded from registered state only; there is no combinational path from `start` to any output.

## Structure
- State encodings IDLE/RUN/DONE live as localparams in the shared arith-unit defines header, alongside the other sequential AU blocks.
- Exactly one sub-module: `AU_inc` with `WIDTH=SLICE`, `ARCH=ARCH`, instantiated once and shared across all slices through an indexed part-select mux.
- Remaining logic is the FSM, `idx` counter, `z` register with slice write-back, and `cout` flag.

## Test plan
- SLICE=8, NSLICE=4, `a=0x00000012` -> `z=0x00000013`, `cout=0`, `done` in cycle 2, upper slices unchanged.
- `a=0x0000FFFF` -> `z=0x00010000`, `cout=0`, m=3, `done` in cycle 4.
- `a=0xFFFFFFFF` -> `z=0x00000000`, `cout=1`, m=4, `done` in cycle 5.
- `start` pulsed during RUN with a different `a` -> ignored; result is from the first operand. `start` held in the DONE cycle with `a=0x000000FE` -> accepted; next result `0x000000FF` with `done` 2 cycles later.
- `rst_n` low in cycle 2 of an `a=0xFFFFFFFF` run -> `z=0`, `cout=0`, `busy=0`, `ready=1` immediately; no `done`. A fresh start then completes normally.
- SLICE=1, NSLICE=1, `a=1` -> `z=0`, `cout=1`, `done` in cycle 2. SLICE=3, NSLICE=3, `a=9'h1FF` -> `z=0`, `cout=1`.
